// File: rtl/eightbit_pkg.sv
// Shared encodings for the memory arbiter: FSM states, one-hot grants,
// the latched-request record and the store byte-merge helper.
package eightbit_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IF   = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    typedef struct packed {
        logic       is_d;
        logic       is_st;
        logic [7:0] wbyte;
    } req_t;

    // The stored byte lands in the most significant lane (big-endian byte at addr).
    function automatic logic [31:0] merge_hi_byte(input logic [7:0] b, input logic [23:0] tail);
        return {b, tail};
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Tie-break between fetch and data requests. MEM_ARB_RR_EN selects round-robin
// with a last-grant flop; otherwise data always wins a tie.
module mem_arb_grant
    import eightbit_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic       clk,
    input  logic       rst,
    input  logic       i_take,
`endif
    input  logic       i_if_req,
    input  logic       i_d_req,
    output logic [1:0] o_gnt
);

`ifdef MEM_ARB_RR_EN
    logic r_last_d;

    // Resets to "data" so the first tie goes to fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_d <= 1'b1;
        end else if (i_take && (o_gnt != GNT_NONE)) begin
            r_last_d <= (o_gnt == GNT_D);
        end
    end
`endif

    always_comb begin
        o_gnt = GNT_NONE;
        if (i_d_req && i_if_req) begin
`ifdef MEM_ARB_RR_EN
            o_gnt = r_last_d ? GNT_IF : GNT_D;
`else
            o_gnt = GNT_D;
`endif
        end else if (i_d_req) begin
            o_gnt = GNT_D;
        end else if (i_if_req) begin
            o_gnt = GNT_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter merging instruction fetch and byte load/store onto a
// 32-bit registered memory port. Optional round-robin tie-break: MEM_ARB_RR_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting; grant a requester and latch its fields
// ST_ISSUE | addr stable, memory samples it at end of cycle
// ST_DATA  | data_in valid; ack reads, or build merged word for a store
// ST_WRITE | we high, memory commits at end of cycle; store ack
module mem_arbiter
    import eightbit_pkg::*;
#(
    parameter int M_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [M_WIDTH-1:0] if_addr,
    output logic               if_ack,
    output logic [31:0]        if_data,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [M_WIDTH-1:0] d_addr,
    input  logic [7:0]         d_wdata,
    output logic               d_ack,
    output logic [7:0]         d_rdata,
    output logic [M_WIDTH-1:0] addr,
    output logic [31:0]        data_out,
    output logic               we,
    input  logic [31:0]        data_in
);

    logic [1:0]         r_state;
    logic [M_WIDTH-1:0] r_addr;
    logic [31:0]        r_data_out;
    logic               r_we;
    req_t               r_req;

    logic [1:0]         w_gnt;
    logic               w_data_phase;
    logic               w_rd_ack;

`ifdef MEM_ARB_RR_EN
    logic               w_idle;
    assign w_idle = (r_state == ST_IDLE);
`endif

    mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
        .clk      (clk),
        .rst      (rst),
        .i_take   (w_idle),
`endif
        .i_if_req (if_req),
        .i_d_req  (d_req),
        .o_gnt    (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_data_out <= '0;
            r_we       <= 1'b0;
            r_req      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt != GNT_NONE) begin
                        r_state     <= ST_ISSUE;
                        r_addr      <= (w_gnt == GNT_D) ? d_addr : if_addr;
                        r_req.is_d  <= (w_gnt == GNT_D);
                        r_req.is_st <= (w_gnt == GNT_D) && d_we;
                        r_req.wbyte <= d_wdata;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_DATA;
                end
                ST_DATA: begin
                    if (r_req.is_st) begin
                        r_data_out <= merge_hi_byte(r_req.wbyte, data_in[23:0]);
                        r_we       <= 1'b1;
                        r_state    <= ST_WRITE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    r_we    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Acks are pure state decodes, suppressed while reset is asserted.
    assign w_data_phase = ~rst & (r_state == ST_DATA);
    assign if_ack       = w_data_phase & ~r_req.is_d;
    assign w_rd_ack     = w_data_phase & r_req.is_d & ~r_req.is_st;
    assign d_ack        = w_rd_ack | (~rst & (r_state == ST_WRITE));

    assign if_data  = if_ack   ? data_in        : '0;
    assign d_rdata  = w_rd_ack ? data_in[31:24] : '0;

    assign addr     = r_addr;
    assign data_out = r_data_out;
    assign we       = r_we;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// against a transaction-level model of arbitration, latency and memory contents.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_data;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [7:0]  d_wdata;
    logic        d_ack;
    logic [7:0]  d_rdata;
    logic [31:0] addr;
    logic [31:0] data_out;
    logic        we;
    logic [31:0] data_in;

    logic        bd_we;
    logic [31:0] bd_addr;
    logic [31:0] bd_word;

    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];

    int checks = 0;
    int errors = 0;

    int          if_acks[$];
    int          d_acks[$];
    logic [31:0] if_vals[$];
    logic [7:0]  d_vals[$];
    logic [31:0] issue_addr;
    logic        ack_we;
    logic [31:0] ack_dout;

    bit          m_last_d;
    int          exp_ic, exp_dc;
    logic [31:0] exp_iv;
    logic [7:0]  exp_dv;

    mem_arbiter #(.M_WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_data  (if_data),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .addr     (addr),
        .data_out (data_out),
        .we       (we),
        .data_in  (data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bi(input logic [31:0] a, input int k);
        return int'((a + 32'(k)) & 32'h0000_00FF);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_mem[bi(a,0)], ref_mem[bi(a,1)], ref_mem[bi(a,2)], ref_mem[bi(a,3)]};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem[bi(a,0)], mem[bi(a,1)], mem[bi(a,2)], mem[bi(a,3)]};
    endfunction

    // Bench memory: one-cycle registered read, big-endian 4-byte write, plus a backdoor loader.
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bi(bd_addr,0)] <= bd_word[31:24];
            mem[bi(bd_addr,1)] <= bd_word[23:16];
            mem[bi(bd_addr,2)] <= bd_word[15:8];
            mem[bi(bd_addr,3)] <= bd_word[7:0];
        end else if (we) begin
            mem[bi(addr,0)] <= data_out[31:24];
            mem[bi(addr,1)] <= data_out[23:16];
            mem[bi(addr,2)] <= data_out[15:8];
            mem[bi(addr,3)] <= data_out[7:0];
        end
        data_in <= {mem[bi(addr,0)], mem[bi(addr,1)], mem[bi(addr,2)], mem[bi(addr,3)]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        ref_mem[bi(a,0)] = w[31:24];
        ref_mem[bi(a,1)] = w[23:16];
        ref_mem[bi(a,2)] = w[15:8];
        ref_mem[bi(a,3)] = w[7:0];
        bd_we   = 1'b1;
        bd_addr = a;
        bd_word = w;
        tick();
        bd_we   = 1'b0;
    endtask

    // Drive requests and record every ack (cycle index counted from the request cycle).
    task automatic run(input bit ui, input logic [31:0] ia, input bit ud, input bit dst,
                       input logic [31:0] da, input logic [7:0] dwd, input int ncyc,
                       input bit hold, input bit pert);
        if_acks.delete(); d_acks.delete(); if_vals.delete(); d_vals.delete();
        ack_we = 1'bx; ack_dout = 'x;
        if_req = ui; if_addr = ia;
        d_req = ud; d_we = dst; d_addr = da; d_wdata = dwd;
        for (int k = 1; k <= ncyc; k++) begin
            tick();
            if (k == 1) issue_addr = addr;
            if (pert && k == 1) begin
                if_addr = ia + 32'h10;
                d_addr  = da + 32'h10;
                d_wdata = ~dwd;
            end
            if (if_ack) begin
                if_acks.push_back(k);
                if_vals.push_back(if_data);
                if (!hold) if_req = 1'b0;
            end
            if (d_ack) begin
                d_acks.push_back(k);
                d_vals.push_back(d_rdata);
                ack_we   = we;
                ack_dout = data_out;
                if (!hold) d_req = 1'b0;
            end
            if (!if_req && !d_req) break;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        repeat (4) tick();
    endtask

    // Transaction model: reads ack 2 cycles after grant, stores 3; loser is granted
    // in the idle cycle after the winner's ack.
    task automatic model_tx(input bit ui, input logic [31:0] ia, input bit ud, input bit dst,
                            input logic [31:0] da, input logic [7:0] dwd);
        int lat_d;
        bit d_first;
        lat_d = dst ? 3 : 2;
        if (ui && ud) begin
`ifdef MEM_ARB_RR_EN
            d_first = !m_last_d;
`else
            d_first = 1'b1;
`endif
        end else begin
            d_first = ud;
        end
        if (ud && d_first) begin
            exp_dc = lat_d;
            if (dst) ref_mem[bi(da,0)] = dwd;
            else     exp_dv = ref_mem[bi(da,0)];
        end
        if (ui) begin
            exp_ic = (ud && d_first) ? lat_d + 3 : 2;
            exp_iv = ref_word(ia);
        end
        if (ud && !d_first) begin
            exp_dc = 3 + lat_d;
            if (dst) ref_mem[bi(da,0)] = dwd;
            else     exp_dv = ref_mem[bi(da,0)];
        end
        m_last_d = (ui && ud) ? !d_first : ud;
    endtask

    task automatic check_tx(input string tag, input bit ui, input bit ud, input bit dst);
        check({tag, "_n_if"}, if_acks.size(), {31'b0, ui});
        check({tag, "_n_d"},  d_acks.size(),  {31'b0, ud});
        if (ui) begin
            check({tag, "_if_cyc"},  (if_acks.size() > 0) ? if_acks[0] : -1, exp_ic);
            check({tag, "_if_data"}, (if_vals.size() > 0) ? if_vals[0] : 'x, exp_iv);
        end
        if (ud) begin
            check({tag, "_d_cyc"}, (d_acks.size() > 0) ? d_acks[0] : -1, exp_dc);
            if (dst) check({tag, "_d_we"}, {31'b0, ack_we}, 32'd1);
            else     check({tag, "_d_data"}, {24'b0, (d_vals.size() > 0) ? d_vals[0] : 8'hxx}, {24'b0, exp_dv});
        end
    endtask

    initial begin
        int          e_if[$];
        int          e_d[$];
        bit          gd;
        bit          saw;
        int          kind;
        int          mism;
        bit          ui, ud, dst;
        logic [31:0] ia, da;
        logic [7:0]  wd;

        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; bd_we = 1'b0; bd_addr = '0; bd_word = '0;
        m_last_d = 1'b1;

        for (int i = 0; i < 64; i++) preload(32'(i * 4), $urandom);
        preload(32'h00, 32'h5001_5100);
        preload(32'h08, 32'h1234_5678);
        preload(32'h10, 32'hDEAD_BEEF);
        preload(32'hE0, 32'hAABB_CCDD);

        check("rst_addr",     addr,               32'h0);
        check("rst_data_out", data_out,           32'h0);
        check("rst_we",       {31'b0, we},        32'h0);
        check("rst_if_ack",   {31'b0, if_ack},    32'h0);
        check("rst_d_ack",    {31'b0, d_ack},     32'h0);
        check("rst_if_data",  if_data,            32'h0);
        check("rst_d_rdata",  {24'b0, d_rdata},   32'h0);

        rst = 1'b0;
        tick();

        // One-shot tie: fetch 0x08 against load 0xE0.
        run(1, 32'h08, 1, 0, 32'hE0, 8'h00, 12, 0, 0);
        model_tx(1, 32'h08, 1, 0, 32'hE0, 8'h00);
        check_tx("tie", 1, 1, 0);
`ifdef MEM_ARB_RR_EN
        check("tie_rr_fetch_first", (if_acks.size() > 0) ? if_acks[0] : -1, 2);
`else
        check("tie_fixed_data_first", (d_acks.size() > 0) ? d_acks[0] : -1, 2);
`endif

        // Both requests held for 12 cycles.
        run(1, 32'h08, 1, 0, 32'hE0, 8'h00, 12, 1, 0);
        e_if.delete(); e_d.delete();
        for (int idle = 0; idle + 2 <= 12; idle += 3) begin
`ifdef MEM_ARB_RR_EN
            gd = !m_last_d;
`else
            gd = 1'b1;
`endif
            if (gd) e_d.push_back(idle + 2);
            else    e_if.push_back(idle + 2);
            m_last_d = gd;
        end
        check("held_n_if", if_acks.size(), e_if.size());
        check("held_n_d",  d_acks.size(),  e_d.size());
        for (int i = 0; i < e_if.size() && i < if_acks.size(); i++) begin
            check("held_if_cyc",  if_acks[i], e_if[i]);
            check("held_if_data", if_vals[i], ref_word(32'h08));
        end
        for (int i = 0; i < e_d.size() && i < d_acks.size(); i++) begin
            check("held_d_cyc",  d_acks[i], e_d[i]);
            check("held_d_data", {24'b0, d_vals[i]}, {24'b0, ref_mem[bi(32'hE0,0)]});
        end

        // Fetch of 0x00.
        run(1, 32'h00, 0, 0, 32'h0, 8'h00, 10, 0, 0);
        model_tx(1, 32'h00, 0, 0, 32'h0, 8'h00);
        check_tx("fetch", 1, 0, 0);
        check("fetch_const", (if_vals.size() > 0) ? if_vals[0] : 'x, 32'h5001_5100);
        check("fetch_issue_addr", issue_addr, 32'h00);

        // Byte store 0x01 to 0xE0, then load 0xE1.
        run(0, 32'h0, 1, 1, 32'hE0, 8'h01, 10, 0, 0);
        model_tx(0, 32'h0, 1, 1, 32'hE0, 8'h01);
        check_tx("store", 0, 1, 1);
        check("store_dout", ack_dout, 32'h01BB_CCDD);
        check("store_mem",  mem_word(32'hE0), 32'h01BB_CCDD);
        run(0, 32'h0, 1, 0, 32'hE1, 8'h00, 10, 0, 0);
        model_tx(0, 32'h0, 1, 0, 32'hE1, 8'h00);
        check_tx("load", 0, 1, 0);
        check("load_const", {24'b0, (d_vals.size() > 0) ? d_vals[0] : 8'hxx}, 32'h0000_00BB);

        // Fetch address changed after grant must be ignored.
        run(1, 32'h00, 0, 0, 32'h0, 8'h00, 10, 0, 1);
        model_tx(1, 32'h00, 0, 0, 32'h0, 8'h00);
        check_tx("pert", 1, 0, 0);

        // Reset in the ISSUE cycle of a load.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'hE0;
        tick();
        rst = 1'b1; d_req = 1'b0;
        #1;
        check("rsti_d_ack", {31'b0, d_ack}, 32'h0);
        tick();
        rst = 1'b0;
        check("rsti_addr", addr, 32'h0);
        check("rsti_we",   {31'b0, we}, 32'h0);
        saw = 1'b0;
        repeat (4) begin tick(); if (d_ack || if_ack) saw = 1'b1; end
        check("rsti_no_ack", {31'b0, saw}, 32'h0);
        m_last_d = 1'b1;
        run(1, 32'h10, 0, 0, 32'h0, 8'h00, 10, 0, 0);
        model_tx(1, 32'h10, 0, 0, 32'h0, 8'h00);
        check_tx("rsti_next", 1, 0, 0);

        // Reset during WRITE: memory still commits, no ack.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 8'h5A;
        tick(); tick(); tick();
        check("rstw_we_high", {31'b0, we}, 32'h1);
        rst = 1'b1; d_req = 1'b0;
        #1;
        check("rstw_d_ack", {31'b0, d_ack}, 32'h0);
        tick();
        rst = 1'b0;
        ref_mem[bi(32'h40,0)] = 8'h5A;
        check("rstw_we_low", {31'b0, we}, 32'h0);
        check("rstw_mem", {24'b0, mem[bi(32'h40,0)]}, 32'h0000_005A);
        saw = 1'b0;
        repeat (4) begin tick(); if (d_ack || if_ack) saw = 1'b1; end
        check("rstw_no_ack", {31'b0, saw}, 32'h0);
        m_last_d = 1'b1;

        // Random traffic: fetch, load, store and ties.
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 3));
            ia   = $urandom;
            da   = $urandom;
            wd   = 8'($urandom);
            ui   = (kind == 0) || (kind == 3);
            ud   = (kind != 0);
            dst  = (kind == 2) || ((kind == 3) && ($urandom_range(0, 1) == 1));
            run(ui, ia, ud, dst, da, wd, 14, 0, 0);
            model_tx(ui, ia, ud, dst, da, wd);
            check_tx("rand", ui, ud, dst);
        end

        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
        check("mem_scan", mism, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the core's pipeline stages and the external 32-bit memory bus. It merges the Fetch stage's instruction-word reads and the load/store path's byte reads and writes onto one `addr`/`data_out`/`data_in`/`we` port. The memory port has one-cycle registered read latency and big-endian 4-byte writes. Byte stores are performed as read-modify-write so that the three neighbouring bytes are preserved.

## Interface
- `M_WIDTH`, 32: address width of all ports.
- `clk` in 1: single clock; everything is sampled on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch request.
- `if_addr` in M_WIDTH: fetch byte address.
- `if_ack` out 1: fetch complete, high for exactly one cycle.
- `if_data` out 32: bytes `addr`..`addr+3`, with `addr` in [31:24]; valid only while `if_ack` is high.
- `d_req` in 1: data request.
- `d_we` in 1: 1 = byte store, 0 = byte load.
- `d_addr` in M_WIDTH: data byte address.
- `d_wdata` in 8: store byte.
- `d_ack` out 1: data access complete, high for one cycle.
- `d_rdata` out 8: load byte; valid only while `d_ack` is high.
- `addr` out M_WIDTH: memory address, registered.
- `data_out` out 32: memory write word, registered.
- `we` out 1: memory write enable, registered.
- `data_in` in 32: memory read word; holds the data for the address sampled at the previous edge.

## Operation
- FSM states: IDLE, ISSUE, DATA, WRITE.
- IDLE
  - With no request, stay in IDLE.
  - Otherwise grant one port. Latch its address, store flag and write byte into `addr` and internal registers, then go to ISSUE.
  - Fixed priority: data wins ties.
- ISSUE: `addr` is stable and the memory samples it at the end of the cycle. Go to DATA.
- DATA: `data_in` is valid.
  - Fetch: `if_ack`=1, `if_data`=`data_in`, go to IDLE.
  - Load: `d_ack`=1, `d_rdata`=`data_in[31:24]`, go to IDLE.
  - Store: register `data_out` = {`d_wdata`, `data_in[23:0]`}, set `we` for the next cycle, go to WRITE.
- WRITE: `we`=1 and the memory commits at the end of the cycle. `d_ack`=1. Go to IDLE, with `we` cleared at the same edge.
- Requesters hold `req` high until their ack. Request fields are latched at grant, so changes before the ack are ignored.
- A requester still asserting `req` in the cycle after its ack is treated as a new request.
- The port that is not granted keeps waiting; it receives no ack and nothing is dropped.
- Address wrap at `addr`+1..3 is left to memory. No alignment is required.

## Timing
- Reset values: state IDLE, `addr`=0, `data_out`=0, `we`=0. `if_ack`, `d_ack`, `if_data` and `d_rdata` are all 0 while `rst` is high.
- Latency, with request seen in IDLE at cycle c:
  - Fetch and load: ack in cycle c+2.
  - Store: ack in cycle c+3, and the memory is updated at the end of c+3.
- Throughput: a read completes every 3 cycles back-to-back; a store every 4.
- Acks are state decodes gated by `~rst`.
- Reset mid-operation: the next edge returns the FSM to IDLE and any access in flight is abandoned without an ack.
  - Exception: `rst` asserted during WRITE. The write still commits at that edge because `we` is already registered high, but no `d_ack` is given.
  - The requester must re-issue after reset.
- Reset takes priority over grant in the same cycle.

## Configuration
- `MEM_ARB_RR_EN` defined: ties in IDLE are resolved round-robin, granting the port not granted last. The last-grant flag resets to "data", so fetch wins the first tie.
  - A lone request is always granted immediately.
- `MEM_ARB_RR_EN` undefined: fixed priority, data over fetch. The last-grant flag is not implemented.

## Structure
- Shared package `eightbit_pkg` holds:
  - the FSM state encodings `ST_IDLE`/`ST_ISSUE`/`ST_DATA`/`ST_WRITE`;
  - the grant encodings `GNT_IF`/`GNT_D`.
- Sub-module `mem_arb_grant` holds the combinational tie-break plus the last-grant flop (present only under `MEM_ARB_RR_EN`). Its outputs are the one-hot grant.
- The top level holds the FSM, the latched request registers and the byte merge.

## Test plan
- All tests use a bench memory with one-cycle registered read and big-endian 4-byte write.
- Fetch, mem[0x00..0x03]=50 01 51 00: `if_req` at addr 0x00 gives `if_ack` 2 cycles later with `if_data`=0x50015100, and `addr`=0x00 during ISSUE.
- Byte store, mem[0xE0..0xE3]=AA BB CC DD: store 0x01 to 0xE0 gives `d_ack` at c+3 and memory 01 BB CC DD. A following load of 0xE1 returns `d_rdata`=0xBB.
- Simultaneous `if_req`(0x08) and `d_req` load (0xE0):
  - Without the macro: data is acked first and fetch follows 3 cycles later.
  - With `MEM_ARB_RR_EN`: fetch is acked first, and a second tie grants data.
- Both requests held continuously for 12 cycles under `MEM_ARB_RR_EN` produce alternating acks with no starvation. Without the macro, fetch never acks while `d_req` stays high.
- Reset timing:
  - `rst` pulsed in the ISSUE cycle of a load: no `d_ack`, state IDLE next cycle, `we`=0.
  - `rst` pulsed during WRITE: memory is updated but there is no `d_ack`.
- Changing `if_addr` from 0x00 to 0x10 in the cycle after grant has no effect: `if_data` still reflects 0x00.
